// File: rtl/jk_ff_monitor_if.sv
// Signal bundle between a JK flip-flop stage (master side) and its monitor (slave side).
interface jk_ff_monitor_if #(
  parameter int CNT_W = 8
);
  logic             Q;
  logic             Q_b;
  logic             clr;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] toggle_cnt;
  logic             cnt_wrap;
  logic             stuck;
  logic             err;
  logic [1:0]       state;

  modport master (
    output Q, Q_b, clr,
    input  rise, fall, toggle_cnt, cnt_wrap, stuck, err, state
  );

  modport slave (
    input  Q, Q_b, clr,
    output rise, fall, toggle_cnt, cnt_wrap, stuck, err, state
  );
endinterface

// File: rtl/jk_ff_monitor.sv
// Tracks the level of a JK flip-flop's Q/Q_b pair: edge pulses, toggle count,
// stuck-output detection and complement-fault detection.
//
// state | meaning
// INIT  | no valid sample seen since reset/clear
// LOW   | last valid sample had Q=0
// HIGH  | last valid sample had Q=1
// FAULT | FAULT_CYCLES consecutive samples with Q==Q_b; absorbing until clr/rst
module jk_ff_monitor #(
  parameter int CNT_W        = 8,
  parameter int STUCK_LIMIT  = 16,
  parameter int FAULT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  jk_ff_monitor_if.slave  bus
);

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_LOW   = 2'd1;
  localparam logic [1:0] ST_HIGH  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  localparam int          BR_W     = (FAULT_CYCLES < 2) ? 1 : $clog2(FAULT_CYCLES + 1);
  localparam logic [15:0] STK_LIM  = 16'(STUCK_LIMIT);
  localparam logic [BR_W-1:0] BR_LIM = BR_W'(FAULT_CYCLES);

  logic [1:0]       state;
  logic             rise;
  logic             fall;
  logic             cnt_wrap;
  logic             stuck;
  logic             err;
  logic [CNT_W-1:0] toggle_cnt;
  logic [15:0]      stable_cnt;
  logic [BR_W-1:0]  bad_run;

  logic             valid;
  logic [CNT_W-1:0] cnt_inc;
  logic             cnt_at_max;
  logic [15:0]      stable_inc;
  logic [BR_W-1:0]  bad_run_inc;
  logic             moved;

  assign valid       = bus.Q != bus.Q_b;
  assign cnt_inc     = toggle_cnt + CNT_W'(1);
  assign cnt_at_max  = &toggle_cnt;
  assign stable_inc  = (stable_cnt == STK_LIM) ? stable_cnt : stable_cnt + 16'd1;
  assign bad_run_inc = bad_run + BR_W'(1);
  // A transition is a valid sample whose level differs from the tracked level.
  assign moved       = ((state == ST_LOW) && bus.Q) || ((state == ST_HIGH) && !bus.Q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_INIT;
      rise       <= 1'b0;
      fall       <= 1'b0;
      cnt_wrap   <= 1'b0;
      stuck      <= 1'b0;
      err        <= 1'b0;
      toggle_cnt <= '0;
      stable_cnt <= '0;
      bad_run    <= '0;
    end else if (bus.clr) begin
      state      <= ST_INIT;
      rise       <= 1'b0;
      fall       <= 1'b0;
      cnt_wrap   <= 1'b0;
      stuck      <= 1'b0;
      err        <= 1'b0;
      toggle_cnt <= '0;
      stable_cnt <= '0;
      bad_run    <= '0;
    end else begin
      rise     <= 1'b0;
      fall     <= 1'b0;
      cnt_wrap <= 1'b0;
      if (state == ST_FAULT) begin
        state <= ST_FAULT;
      end else if (!valid) begin
        bad_run <= bad_run_inc;
        if (bad_run_inc == BR_LIM) begin
          state <= ST_FAULT;
          err   <= 1'b1;
        end
      end else begin
        bad_run <= '0;
        if (state == ST_INIT) begin
          state      <= bus.Q ? ST_HIGH : ST_LOW;
          stable_cnt <= '0;
          stuck      <= 1'b0;
        end else if (moved) begin
          state      <= bus.Q ? ST_HIGH : ST_LOW;
          rise       <= bus.Q;
          fall       <= !bus.Q;
          toggle_cnt <= cnt_inc;
          cnt_wrap   <= cnt_at_max;
          stable_cnt <= '0;
          stuck      <= 1'b0;
        end else begin
          stable_cnt <= stable_inc;
          stuck      <= (stable_inc == STK_LIM);
        end
      end
    end
  end

  assign bus.state      = state;
  assign bus.rise       = rise;
  assign bus.fall       = fall;
  assign bus.cnt_wrap   = cnt_wrap;
  assign bus.stuck      = stuck;
  assign bus.err        = err;
  assign bus.toggle_cnt = toggle_cnt;

endmodule
